muon_serial_tx: RTL and testbench
=================================

# muon_serial_tx

Framed serial transmitter for a sorted-muon list: accepts one `CAND_NUM`-entry `muon_t` array per valid/ready handshake and shifts it out MSB-first on a single-bit line, as sync word, payload and even parity. It replaces the bit-reduction output path after the bitonic sorter output register. It is the transmit end of the muon serial link whose receive end feeds the sorter input.

## Interface
- `CAND_NUM`, 16: number of muon candidates per frame.
- `clk`  in  1: logic clock; all state is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `muons_in` holds a frame to send.
- `in_ready`  out  1: block can accept a frame this cycle.
- `muons_in`  in  `muon_t [0:CAND_NUM-1]`: sorted candidates; entry 0 is sent first.
- `dout`  out  1: registered serial data.
- `busy`  out  1: a frame is being transmitted (state is not IDLE).
- `frame_cnt`  out  16: count of completed frames, wraps.

## Operation
- `MUON_WIDTH = PT_WIDTH + IDX_WIDTH`.
- `PAYLOAD_BITS = CAND_NUM*MUON_WIDTH`.
- `FRAME_BITS = SYNC_WIDTH + PAYLOAD_BITS + 1`. This is 137 with package defaults (PT 4, IDX 4).
- Bit order: `SYNC_PATTERN` (8'hA5) MSB-first, then muon 0..CAND_NUM-1. Each muon is sent as `pt` MSB-first, then `idx` MSB-first. The frame ends with the parity bit, which is the XOR of all payload bits (even parity over the payload only).
- FSM states: IDLE, SYNC, PAYLOAD, PARITY.
  - IDLE: `dout`=0, `in_ready`=1. On `in_valid` the block loads the shift register, captures parity of `muons_in`, and goes to SYNC.
  - SYNC: emits 8 sync bits, then goes to PAYLOAD.
  - PAYLOAD: emits `PAYLOAD_BITS` bits from the shift register, then goes to PARITY.
  - PARITY: emits the parity bit and increments `frame_cnt`. `in_ready`=1 in this state. If `in_valid` is high, the block loads the next frame and goes to SYNC (back-to-back, no idle gap). Otherwise it goes to IDLE.
- `in_ready` is a decode of the registered state and is high only in IDLE and PARITY. `in_valid` in any other state is ignored, and the upstream stage must hold its data.
- `muons_in` is sampled only on the accept cycle. Later changes have no effect on the frame in flight.
- A single bit counter, sized `$clog2(PAYLOAD_BITS)`, is shared by SYNC and PAYLOAD and cleared on each state entry.
- `frame_cnt` increments by 1 per PARITY cycle and wraps from 16'hFFFF to 0.

## Timing
- Reset values: `dout`=0, `busy`=0, `frame_cnt`=0, state IDLE. `in_ready` is 1 while in reset because the state is IDLE.
- Reset mid-frame: output returns to reset values immediately (asynchronously). The partial frame is discarded and not counted. After `rst_n` rises, the first handshake starts a fresh frame.
- Accept at edge T (`in_valid && in_ready` sampled) gives:
  - sync bit 7 on `dout` after edge T+1;
  - last sync bit after T+8;
  - first payload bit after T+9;
  - parity bit after T+9+`PAYLOAD_BITS` (T+137 for defaults).
- Latency from accept to first bit is 1 cycle. One frame occupies exactly `FRAME_BITS` cycles.
- `busy` is high from T+1 through the parity cycle.
- Back-to-back frames: if accepted in PARITY, the next sync MSB follows the parity bit on the next cycle.
- `frame_cnt` updates on the same edge that leaves PARITY.

## Structure
- `bitonic_sorter_pkg` already holds `muon_t`, `PT_WIDTH` and `IDX_WIDTH`. Add these to it:
  - `MUON_WIDTH`;
  - `SYNC_WIDTH` = 8;
  - `SYNC_PATTERN` = 8'hA5;
  - `tx_state_t` enum (IDLE, SYNC, PAYLOAD, PARITY).
- The matching receiver will import the same constants.
- One natural sub-module: `muon_pack`. It is combinational and flattens `muon_t [0:CAND_NUM-1]` into the `PAYLOAD_BITS` vector in transmit order with muon 0 at the MSB, and reduces it to the parity bit.
- The FSM, counter and shift register stay in `muon_serial_tx`.

## Test plan
- Single frame, default params, muon i = {pt=i, idx=15-i}:
  - `dout` after the accept edge shows 10100101, then 0000_1111, 0001_1110, … 1111_0000, then parity=0;
  - then `dout`=0, `busy`=0, `frame_cnt`=1.
- All-zero muons except muon 5 pt=4'h1 → parity bit 1.
- Two frames with `in_valid` held high: second sync starts the cycle after the first parity bit, with no gap. Bits 137..273 carry frame 2, and `frame_cnt`=2.
- `in_valid` pulsed in PAYLOAD with different data → ignored. The frame in flight is unchanged, and `in_ready` stays 0 there.
- Assert `rst_n`=0 at payload bit 40 → `dout`=0, `busy`=0 and `frame_cnt`=0 immediately. After release, a new accept produces a full, correct frame.
- Preload by sending 65535 frames (or force) → `frame_cnt` reads 16'hFFFF, and the next completed frame makes it 0.

Source files
------------

// File: rtl/bitonic_sorter_pkg.sv
// Shared types and constants for the bitonic sorter and the muon serial link.
// The serial transmitter and the matching receiver both import this package.
package bitonic_sorter_pkg;

    localparam int unsigned PT_WIDTH  = 4;
    localparam int unsigned IDX_WIDTH = 4;

    typedef struct packed {
        logic [PT_WIDTH-1:0]  pt;
        logic [IDX_WIDTH-1:0] idx;
    } muon_t;

    // Serial link framing
    localparam int unsigned MUON_WIDTH = PT_WIDTH + IDX_WIDTH;
    localparam int unsigned SYNC_WIDTH = 8;
    localparam logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 8'hA5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        PAYLOAD = 2'd2,
        PARITY  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/muon_serial_tx_if.sv
// Frame handshake between the sorter output register and the serial transmitter.
interface muon_serial_tx_if
    import bitonic_sorter_pkg::*;
#(
    parameter int unsigned CAND_NUM = 16
);

    logic  in_valid;
    logic  in_ready;
    muon_t muons_in [0:CAND_NUM-1];

    modport master (
        output in_valid,
        output muons_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  muons_in,
        output in_ready
    );

endinterface

// File: rtl/muon_pack.sv
// Flattens a muon list into transmit order (muon 0 at the MSB, pt above idx)
// and reduces it to the even-parity bit of the payload.
module muon_pack
    import bitonic_sorter_pkg::*;
#(
    parameter int unsigned CAND_NUM     = 16,
    parameter int unsigned PAYLOAD_BITS = CAND_NUM * MUON_WIDTH
) (
    input  muon_t                   muons [0:CAND_NUM-1],
    output logic [PAYLOAD_BITS-1:0] payload,
    output logic                    parity
);

    always_comb begin
        payload = '0;
        for (int unsigned i = 0; i < CAND_NUM; i++) begin
            payload[PAYLOAD_BITS-1-i*MUON_WIDTH -: MUON_WIDTH] = muons[i];
        end
    end

    assign parity = ^payload;

endmodule

// File: rtl/muon_serial_tx.sv
// Framed MSB-first serial transmitter: sync word, packed muon payload, even parity.
// Accepts the next frame in the parity cycle so back-to-back frames have no gap.
module muon_serial_tx
    import bitonic_sorter_pkg::*;
#(
    parameter int unsigned CAND_NUM = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    muon_serial_tx_if.slave   bus,
    output logic              dout,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned PAYLOAD_BITS = CAND_NUM * MUON_WIDTH;
    localparam int unsigned CNT_W        = $clog2(PAYLOAD_BITS);
    localparam int unsigned SEL_W        = $clog2(SYNC_WIDTH);
    localparam int unsigned FCNT_W       = 16;

    tx_state_t               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
    logic                    parity_q, parity_d;
    logic                    dout_q, dout_d;
    logic                    busy_q, busy_d;
    logic [FCNT_W-1:0]       frame_cnt_q, frame_cnt_d;

    logic [PAYLOAD_BITS-1:0] payload;
    logic                    payload_parity;
    logic                    accept_c;
    logic [SEL_W-1:0]        sync_sel_c;

    muon_pack #(
        .CAND_NUM     (CAND_NUM),
        .PAYLOAD_BITS (PAYLOAD_BITS)
    ) u_pack (
        .muons   (bus.muons_in),
        .payload (payload),
        .parity  (payload_parity)
    );

    // Ready is a pure decode of the registered state
    assign bus.in_ready = (state_q == IDLE) || (state_q == PARITY);
    assign accept_c     = bus.in_valid && bus.in_ready;
    assign sync_sel_c   = SEL_W'(SYNC_WIDTH - 1) - SEL_W'(cnt_q);

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        parity_d    = parity_q;
        dout_d      = 1'b0;
        busy_d      = (state_q != IDLE);
        frame_cnt_d = frame_cnt_q;

        if (accept_c) begin
            shreg_d  = payload;
            parity_d = payload_parity;
        end

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = SYNC;
                    cnt_d   = '0;
                end
            end
            SYNC: begin
                dout_d = SYNC_PATTERN[sync_sel_c];
                if (cnt_q == CNT_W'(SYNC_WIDTH - 1)) begin
                    state_d = PAYLOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PAYLOAD: begin
                dout_d  = shreg_q[PAYLOAD_BITS-1];
                shreg_d = {shreg_q[PAYLOAD_BITS-2:0], 1'b0};
                if (cnt_q == CNT_W'(PAYLOAD_BITS - 1)) begin
                    state_d = PARITY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                dout_d      = parity_q;
                frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                if (accept_c) begin
                    state_d = SYNC;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            dout_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            parity_q    <= parity_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign dout      = dout_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_muon_serial_tx.sv
// Directed bench for muon_serial_tx: frame contents, parity, back-to-back,
// ignored handshakes, mid-frame reset and frame counter wrap.
module tb_muon_serial_tx;
    import bitonic_sorter_pkg::*;

    localparam int unsigned CAND_NUM     = 16;
    localparam int unsigned PAYLOAD_BITS = CAND_NUM * MUON_WIDTH;
    localparam int unsigned FRAME_BITS   = SYNC_WIDTH + PAYLOAD_BITS + 1;
    localparam int unsigned CAP_W        = 2 * FRAME_BITS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dout;
    logic        busy;
    logic [15:0] frame_cnt;

    muon_serial_tx_if #(.CAND_NUM(CAND_NUM)) bus ();

    muon_serial_tx #(.CAND_NUM(CAND_NUM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dout      (dout),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    muon_t d_zero [0:CAND_NUM-1];
    muon_t d_ramp [0:CAND_NUM-1];
    muon_t d_one  [0:CAND_NUM-1];
    muon_t d_mix  [0:CAND_NUM-1];

    logic [CAP_W-1:0]      cap;
    logic [FRAME_BITS-1:0] fexp;

    task automatic check(input string tag, input logic [CAP_W-1:0] obs, input logic [CAP_W-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference frame built directly from the bit-order definition
    function automatic logic [FRAME_BITS-1:0] frame_of(input muon_t m [0:CAND_NUM-1]);
        logic [PAYLOAD_BITS-1:0] p;
        p = '0;
        for (int i = 0; i < int'(CAND_NUM); i++) begin
            p = {p[PAYLOAD_BITS-MUON_WIDTH-1:0], m[i].pt, m[i].idx};
        end
        return {8'hA5, p, ^p};
    endfunction

    // Present a frame and leave the bench at the negedge after the accept edge
    task automatic start(input muon_t m [0:CAND_NUM-1], input bit hold);
        @(negedge clk);
        bus.muons_in = m;
        bus.in_valid = 1'b1;
        check("ready_at_accept", CAP_W'(bus.in_ready), CAP_W'(1));
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    // Sample n serial bits; optionally raise valid with new data and drop it later
    task automatic capture(input int n, input int raise_at, input int drop_at,
                           input muon_t alt [0:CAND_NUM-1]);
        cap = '0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            cap = {cap[CAP_W-2:0], dout};
            if (j == 1) check("busy_first_bit", CAP_W'(busy), CAP_W'(1));
            if (j == raise_at) begin
                check("ready_low_midframe", CAP_W'(bus.in_ready), CAP_W'(0));
                bus.muons_in = alt;
                bus.in_valid = 1'b1;
            end
            if (j == drop_at) bus.in_valid = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < int'(CAND_NUM); i++) begin
            d_zero[i] = '{pt: 4'h0, idx: 4'h0};
            d_ramp[i] = '{pt: 4'(i), idx: 4'(15 - i)};
            d_one[i]  = '{pt: (i == 5) ? 4'h1 : 4'h0, idx: 4'h0};
            d_mix[i]  = '{pt: 4'(15 - i), idx: 4'(i * 3)};
        end

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.muons_in = d_zero;
        #1;
        check("rst_dout",     CAP_W'(dout),         CAP_W'(0));
        check("rst_busy",     CAP_W'(busy),         CAP_W'(0));
        check("rst_fcnt",     CAP_W'(frame_cnt),    CAP_W'(0));
        check("rst_in_ready", CAP_W'(bus.in_ready), CAP_W'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single ramp frame
        start(d_ramp, 1'b0);
        capture(FRAME_BITS, -1, -1, d_zero);
        check("ramp_frame", CAP_W'(cap[FRAME_BITS-1:0]), CAP_W'(frame_of(d_ramp)));
        check("ramp_head",  CAP_W'(cap[136:113]),        CAP_W'(24'hA50F1E));
        check("ramp_tail",  CAP_W'(cap[8:0]),            CAP_W'(9'h1E0));
        @(negedge clk);
        check("ramp_idle_dout", CAP_W'(dout),      CAP_W'(0));
        check("ramp_idle_busy", CAP_W'(busy),      CAP_W'(0));
        check("ramp_fcnt",      CAP_W'(frame_cnt), CAP_W'(1));

        // Single set bit gives odd payload
        start(d_one, 1'b0);
        capture(FRAME_BITS, -1, -1, d_zero);
        check("one_frame", CAP_W'(cap[FRAME_BITS-1:0]),
              CAP_W'({8'hA5, 128'h00000000001000000000000000000000, 1'b1}));
        check("one_parity", CAP_W'(cap[0]), CAP_W'(1));
        @(negedge clk);
        check("one_fcnt", CAP_W'(frame_cnt), CAP_W'(2));

        // Back-to-back: valid held, data changed mid-frame for frame 2
        start(d_ramp, 1'b1);
        capture(2 * FRAME_BITS, 60, 2 * FRAME_BITS - 1, d_mix);
        check("b2b_frames", cap, {frame_of(d_ramp), frame_of(d_mix)});
        check("b2b_seam",   CAP_W'(cap[FRAME_BITS+1:FRAME_BITS-8]), CAP_W'(10'b0_0_10100101));
        @(negedge clk);
        check("b2b_fcnt", CAP_W'(frame_cnt), CAP_W'(4));
        check("b2b_busy", CAP_W'(busy),      CAP_W'(0));

        // Handshake attempted during payload is ignored
        start(d_one, 1'b0);
        capture(FRAME_BITS, 40, 41, d_ramp);
        check("ignore_frame", CAP_W'(cap[FRAME_BITS-1:0]),
              CAP_W'({8'hA5, 128'h00000000001000000000000000000000, 1'b1}));
        @(negedge clk);
        check("ignore_busy", CAP_W'(busy),      CAP_W'(0));
        check("ignore_dout", CAP_W'(dout),      CAP_W'(0));
        check("ignore_fcnt", CAP_W'(frame_cnt), CAP_W'(5));

        // Reset at payload bit 40 (a 1 bit for d_mix)
        start(d_mix, 1'b0);
        capture(SYNC_WIDTH + 41, -1, -1, d_zero);
        fexp = frame_of(d_mix);
        check("pre_rst_bits", CAP_W'(cap[48:0]), CAP_W'(fexp[136:88]));
        check("pre_rst_dout", CAP_W'(dout),      CAP_W'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_dout",  CAP_W'(dout),         CAP_W'(0));
        check("midrst_busy",  CAP_W'(busy),         CAP_W'(0));
        check("midrst_fcnt",  CAP_W'(frame_cnt),    CAP_W'(0));
        check("midrst_ready", CAP_W'(bus.in_ready), CAP_W'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start(d_ramp, 1'b0);
        capture(FRAME_BITS, -1, -1, d_zero);
        check("post_rst_frame", CAP_W'(cap[FRAME_BITS-1:0]), CAP_W'(frame_of(d_ramp)));
        @(negedge clk);
        check("post_rst_fcnt", CAP_W'(frame_cnt), CAP_W'(1));

        // Counter wrap from 16'hFFFF
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        check("preload_fcnt", CAP_W'(frame_cnt), CAP_W'(16'hFFFF));
        start(d_mix, 1'b0);
        capture(FRAME_BITS, -1, -1, d_zero);
        check("wrap_frame", CAP_W'(cap[FRAME_BITS-1:0]), CAP_W'(frame_of(d_mix)));
        @(negedge clk);
        check("wrap_fcnt", CAP_W'(frame_cnt), CAP_W'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
